// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Three-port arbiter/sequencer in front of mem_controller. Port 0 is display
//   scanout, port 1 rasterizer read, port 2 rasterizer write-back. One request
//   is accepted at a time. The arbiter drives the controller command port with
//   the required hold time, returns read data to the winning port, and
//   enforces write occupancy and post-transaction recovery with a counter
//   because the controller reports no write completion.
//
// Ports
//   clk2         in   clock
//   rst          in   synchronous, active-high reset
//   req_read     in   [2:0]   per-port read request (level, held until ack)
//   req_write    in   [2:0]   per-port write request (level, held until ack)
//   req_addr     in   [59:0]  port p address at [20p+19:20p]
//   req_wrdata   in   [191:0] port p write data at [64p+63:64p]
//   req_ack      out  [2:0]   one-cycle pulse, request consumed
//   rd_valid     out  [2:0]   one-cycle pulse, rd_data valid for that port
//   rd_data      out  [31:0]  read return data (shared)
//   mem_addr     out  [19:0]  controller address
//   mem_read     out          controller read command
//   mem_write    out          controller write command
//   mem_wrdata   out  [63:0]  controller write data
//   mem_ready    in           controller read-complete pulse
//   mem_rddata   in   [31:0]  controller read data
//   busy         out          high whenever the sequencer is not idle
//   timeout_err  out          sticky read-timeout flag, cleared by rst
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int CMD_HOLD   = 2,
    parameter int WR_CYCLES  = 64,
    parameter int GAP_CYCLES = 4,
    parameter int RD_TIMEOUT = 255,
    parameter int PRIO0      = 1
) (
    input  logic         clk2,
    input  logic         rst,
    input  logic [2:0]   req_read,
    input  logic [2:0]   req_write,
    input  logic [59:0]  req_addr,
    input  logic [191:0] req_wrdata,
    output logic [2:0]   req_ack,
    output logic [2:0]   rd_valid,
    output logic [31:0]  rd_data,
    output logic [19:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [63:0]  mem_wrdata,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rddata,
    output logic         busy,
    output logic         timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_WAIT_RD = 3'd3;
    localparam logic [2:0] S_WAIT_WR = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    // One shared counter serves every timed state; it only ever runs in one
    // state at a time and is cleared on each state entry.
    localparam int MAX_AB = (CMD_HOLD > WR_CYCLES) ? CMD_HOLD : WR_CYCLES;
    localparam int MAX_CD = (GAP_CYCLES > RD_TIMEOUT) ? GAP_CYCLES : RD_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_HOLD - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             op_rd_q, op_rd_d;
    logic [1:0]       last_q, last_d;
    logic [19:0]      mem_addr_q, mem_addr_d;
    logic [63:0]      mem_wrdata_q, mem_wrdata_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [2:0]       req_ack_q, req_ack_d;
    logic [2:0]       rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             timeout_q, timeout_d;

    logic [2:0] pend;
    logic [1:0] win;

    // Strict priority for port 0 (when enabled), otherwise rotate starting
    // just after the most recently granted port.
    function automatic logic [1:0] pick_winner(input logic [2:0] p_pend,
                                               input logic [1:0] p_last);
        logic [1:0] idx;
        logic [1:0] w;
        logic       found;
        w     = 2'd0;
        found = 1'b0;
        idx   = p_last;
        if (PRIO0 != 0 && p_pend[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!found && p_pend[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] p);
        case (p)
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [19:0] port_addr(input logic [59:0] v, input logic [1:0] p);
        case (p)
            2'd1:    return v[39:20];
            2'd2:    return v[59:40];
            default: return v[19:0];
        endcase
    endfunction

    function automatic logic [63:0] port_wrdata(input logic [191:0] v, input logic [1:0] p);
        case (p)
            2'd1:    return v[127:64];
            2'd2:    return v[191:128];
            default: return v[63:0];
        endcase
    endfunction

    assign pend = req_read | req_write;
    assign win  = pick_winner(pend, last_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        op_rd_d      = op_rd_q;
        last_d       = last_q;
        mem_addr_d   = mem_addr_q;
        mem_wrdata_d = mem_wrdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        req_ack_d    = 3'b000;
        rd_valid_d   = 3'b000;
        rd_data_d    = rd_data_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE: begin
                // Port selection and latching happen on the edge into GRANT,
                // so ack, address and data all appear in the GRANT cycle.
                if (|pend) begin
                    sel_d        = win;
                    last_d       = win;
                    mem_addr_d   = port_addr(req_addr, win);
                    mem_wrdata_d = port_wrdata(req_wrdata, win);
                    // Read wins when both bits are set; the ack drops the write.
                    op_rd_d      = req_read[win];
                    req_ack_d    = onehot3(win);
                    state_d      = S_GRANT;
                end
            end
            S_GRANT: begin
                mem_read_d  = op_rd_q;
                mem_write_d = !op_rd_q;
                cnt_d       = '0;
                state_d     = S_CMD;
            end
            S_CMD: begin
                if (cnt_q == CMD_LAST) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = op_rd_q ? S_WAIT_RD : S_WAIT_WR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_RD: begin
                if (mem_ready) begin
                    rd_data_d  = mem_rddata;
                    rd_valid_d = onehot3(sel_q);
                    cnt_d      = '0;
                    state_d    = S_GAP;
                end else if (cnt_q == RD_LAST) begin
                    // Complete the transaction anyway so the requester is
                    // never left waiting forever.
                    rd_data_d  = 32'd0;
                    rd_valid_d = onehot3(sel_q);
                    timeout_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_WR: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            op_rd_q      <= 1'b0;
            last_q       <= 2'd2;
            mem_addr_q   <= 20'd0;
            mem_wrdata_q <= 64'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            req_ack_q    <= 3'b000;
            rd_valid_q   <= 3'b000;
            rd_data_q    <= 32'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            op_rd_q      <= op_rd_d;
            last_q       <= last_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrdata_q <= mem_wrdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            req_ack_q    <= req_ack_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            timeout_q    <= timeout_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wrdata  = mem_wrdata_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_q;

endmodule
